// File: rtl/prob6_rr_arbiter.sv
// rtl/prob6_rr_arbiter.sv - four-requester round-robin arbiter with optional hold watchdog
// Optional feature macro: ARB_WATCHDOG_EN (hold counter, revoke path and timeout pulse).
module prob6_rr_arbiter #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] owner,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    GRANT = 3'b010,
    GAP   = 3'b100
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] pick;
  logic       rel;
  logic       revoke;

  // First requester at or after ptr, wrapping modulo 4; scanned farthest-first so the nearest wins.
  always_comb begin
    pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        pick = ptr + 2'(k);
      end
    end
  end

  // The owner gives the resource back by finishing or by dropping its request.
  assign rel = done || !req[owner];

`ifdef ARB_WATCHDOG_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_cnt;

  // Counts cycles spent in GRANT; cleared while waiting so every grant starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= 8'd0;
    end else if (state == GRANT) begin
      hold_cnt <= hold_cnt + 8'd1;
    end else begin
      hold_cnt <= 8'd0;
    end
  end

  // A release on the limit cycle wins over the revoke, so no timeout is flagged then.
  assign revoke = (state == GRANT) && (hold_cnt == HOLD_LAST) && !rel;
`else
  // Without the watchdog grants never expire; legal HOLD_MAX values keep this constant low.
  assign revoke = (HOLD_MAX == 0);
`endif

  // Main controller: state, rotation pointer and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      gnt     <= 4'b0000;
      owner   <= 2'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state <= GRANT;
            owner <= pick;
            gnt   <= 4'b0001 << pick;
            busy  <= 1'b1;
          end
        end
        GRANT: begin
          if (rel || revoke) begin
            state   <= GAP;
            ptr     <= owner + 2'd1;
            gnt     <= 4'b0000;
            timeout <= revoke;
          end
        end
        GAP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prob6_rr_arbiter.sv
// tb/tb_prob6_rr_arbiter.sv - scoreboard bench for prob6_rr_arbiter against a behavioural model
module tb_prob6_rr_arbiter;

  localparam int HM = 4;
`ifdef ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;

  prob6_rr_arbiter #(.HOLD_MAX(HM)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_no   = 0;

  // Behavioural model: who holds the resource, for how many cycles, and who is next in line.
  int m_cur  = -1;  // current holder, -1 when nobody holds it
  int m_last = 0;   // last holder shown on owner
  int m_ptr  = 0;   // requester with top priority
  int m_held = 0;   // grant cycles used so far by the current holder
  bit m_gap  = 1'b0;
  bit m_to   = 1'b0;

  task automatic step(input logic r, input logic [3:0] rq, input logic d);
    exp_t e;
    bit   rel;
    bit   rev;
    bit   found;
    if (r) begin
      m_cur = -1; m_last = 0; m_ptr = 0; m_held = 0; m_gap = 1'b0; m_to = 1'b0;
    end else if (m_gap) begin
      m_gap = 1'b0;
      m_to  = 1'b0;
    end else if (m_cur >= 0) begin
      rel = d || !rq[m_cur];
      rev = WD && (m_held >= HM);
      if (rel || rev) begin
        m_ptr = (m_cur + 1) % 4;
        m_to  = !rel;
        m_gap = 1'b1;
        m_cur = -1;
      end else begin
        m_held++;
      end
    end else if (rq != 4'b0000) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (!found && rq[(m_ptr + k) % 4]) begin
          m_cur = (m_ptr + k) % 4;
          found = 1'b1;
        end
      end
      m_last = m_cur;
      m_held = 1;
    end
    e.gnt     = (m_cur >= 0) ? 4'(1 << m_cur) : 4'b0000;
    e.owner   = 2'(m_last);
    e.busy    = (m_cur >= 0) || m_gap;
    e.timeout = m_to;
    q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic [3:0] rq, input logic d);
    @(negedge clk);
    rst  = r;
    req  = rq;
    done = d;
    step(r, rq, d);
  endtask

  // Monitor: every rising edge produces one output word, compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty cycle %0d: got gnt=%b owner=%0d busy=%b timeout=%b, required a queued expectation",
                 cyc_no, gnt, owner, busy, timeout);
      end else begin
        e = q.pop_front();
        if ({gnt, owner, busy, timeout} !== e) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got gnt=%b owner=%0d busy=%b timeout=%b, required gnt=%b owner=%0d busy=%b timeout=%b",
                   cyc_no, gnt, owner, busy, timeout, e.gnt, e.owner, e.busy, e.timeout);
        end
      end
    end
  end

  initial begin
    logic [3:0] rq;
    logic       d;
    int         guard;

    // Expectation for the very first edge, taken with reset held.
    step(1'b1, 4'b0000, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0);

    // Single request from requester 2, done after a few grant cycles.
    cyc(1'b0, 4'b0100, 1'b0);
    cyc(1'b0, 4'b0100, 1'b0);
    cyc(1'b0, 4'b0100, 1'b0);
    cyc(1'b0, 4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0000, 1'b0);

    // All requesting, done pulsed in every grant: rotation order.
    for (int i = 0; i < 20; i++) cyc(1'b0, 4'b1111, (m_cur >= 0));

    // Requester 3 served, then 0 and 3 contend: pointer wraps to 0.
    guard = 0;
    while (m_cur != 3 && guard < 10) begin
      cyc(1'b0, 4'b1000, 1'b0);
      guard++;
    end
    for (int i = 0; i < 16; i++) cyc(1'b0, 4'b1001, (m_cur >= 0) && (m_held >= 2));
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0000, 1'b0);

    // Requester 1 holds forever: watchdog revoke, or an unbroken grant without it.
    for (int i = 0; i < 25; i++) cyc(1'b0, 4'b0010, 1'b0);

    // done exactly on the watchdog limit cycle.
    for (int i = 0; i < 20; i++) cyc(1'b0, 4'b0010, (m_cur >= 0) && (m_held == HM));

    // Owner drops its request while another requester waits.
    for (int i = 0; i < 16; i++) begin
      rq = 4'b0101;
      if (m_cur >= 0 && m_held == 2) rq[m_cur] = 1'b0;
      cyc(1'b0, rq, 1'b0);
    end

    // Asynchronous reset while requester 3 holds the grant.
    guard = 0;
    while (m_cur != 3 && guard < 10) begin
      cyc(1'b0, 4'b1000, 1'b0);
      guard++;
    end
    cyc(1'b0, 4'b1000, 1'b0);
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL pre_reset_grant: got gnt=%b, required 1000", gnt);
    end
    rst = 1'b1;
    req = 4'b1001;
    done = 1'b0;
    step(1'b1, 4'b1001, 1'b0);
    #1;
    n_checks++;
    if ({gnt, busy, owner} !== 7'b0) begin
      n_fail++;
      $display("FAIL async_reset: got gnt=%b busy=%b owner=%0d, required all zero", gnt, busy, owner);
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, 4'b1001, (m_cur >= 0) && (m_held >= 2));

    // Randomized traffic: sticky requests, occasional done, extra done on the limit cycle.
    rq = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(3) == 0) rq = 4'($urandom_range(15));
      d = ($urandom_range(4) == 0);
      if (m_cur >= 0 && m_held == HM && $urandom_range(1) == 0) d = 1'b1;
      cyc(1'b0, rq, d);
    end

    @(posedge clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
